ahb_to_apb_bridge: RTL

//  Single-clock AHB-Lite slave to APB4 master bridge; sits directly upstream of the APB peripherals/memories.

---
 rtl/apb_bridge_pkg.sv | 25 ++
 rtl/apb_strb_gen.sv | 27 ++
 rtl/ahb_to_apb_bridge.sv | 129 ++++++++++++
 3 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-Lite to APB4 bridge: FSM state encoding
// and AHB bus constants.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_strb_gen.sv
// APB write-strobe generator.
//   hsize_i   : captured AHB transfer size
//   addr_lo_i : captured address bits [1:0]
//   write_i   : captured write flag (reads produce no strobes)
//   strb_o    : byte-lane strobes
module apb_strb_gen
  import apb_bridge_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_lo_i,
  input  logic       write_i,
  output logic [3:0] strb_o
);

  always_comb begin
    strb_o = 4'h0;
    if (write_i) begin
      case (hsize_i)
        HSIZE_BYTE: strb_o = 4'b0001 << addr_lo_i;
        HSIZE_HALF: strb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        // Word and the unsupported wider sizes drive all lanes.
        default:    strb_o = 4'hF;
      endcase
    end
  end

endmodule

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge. Each accepted NONSEQ/SEQ transfer
// becomes one APB SETUP+ACCESS pair; AHB is stalled via HREADYOUT and a
// PSLVERR turns into a two-cycle AHB ERROR response when P_ERR_EN is set.
//   AHB side : HSEL/HADDR/HTRANS/HWRITE/HSIZE/HPROT/HWDATA/HREADY in,
//              HREADYOUT/HRESP/HRDATA out
//   APB side : PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT out,
//              PREADY/PRDATA/PSLVERR in
module ahb_to_apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 32,
  parameter bit          P_ERR_EN  = 1'b1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [3:0]           HPROT,
  input  logic [31:0]          HWDATA,
  input  logic                 HREADY,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [31:0]          HRDATA,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  output logic [2:0]           PPROT,
  input  logic                 PREADY,
  input  logic [31:0]          PRDATA,
  input  logic                 PSLVERR
);

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   addr_q;
  logic                   write_q;
  logic [2:0]             size_q;
  logic [2:0]             prot_q;
  logic [31:0]            hrdata_q, hrdata_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   hreadyout_q, hreadyout_d;
  logic                   hresp_q, hresp_d;
  logic                   accept;
  logic                   load;
  logic                   unused_hprot;

  assign unused_hprot = ^HPROT[3:2];

  assign accept = HSEL & HREADY & HTRANS[1];
  // A new address phase can only be taken while the bridge is ready.
  assign load   = accept & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  always_comb begin
    state_d  = state_q;
    hrdata_d = hrdata_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          if (!write_q) hrdata_d = PRDATA;
          state_d = (PSLVERR && P_ERR_EN) ? ST_ERR1 : ST_DONE;
        end
      end
      ST_ERR1:   state_d = ST_DONE;
      ST_DONE:   state_d = accept ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they switch glitch-free.
    psel_d      = (state_d == ST_SETUP) | (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    hreadyout_d = (state_d == ST_IDLE) | (state_d == ST_DONE);
    // ERROR lasts for ERR1 and the DONE cycle that immediately follows it.
    hresp_d     = (state_d == ST_ERR1) | ((state_q == ST_ERR1) & (state_d == ST_DONE));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      prot_q      <= 3'd0;
      hrdata_q    <= 32'h0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      hrdata_q    <= hrdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      if (load) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
        prot_q  <= {~HPROT[0], 1'b0, HPROT[1]};
      end
    end
  end

  apb_strb_gen u_strb_gen (
    .hsize_i   (size_q),
    .addr_lo_i (addr_q[1:0]),
    .write_i   (write_q),
    .strb_o    (PSTRB)
  );

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = HWDATA;
  assign PPROT     = prot_q;

endmodule
